// File: rtl/array_feed_pl.sv
// array_feed_pl: buffers read-response cache lines in a small FIFO and sequences
// the pipelined accumulator so exactly num_lines lines are summed lane-wise.
// The accumulated line is captured when the accumulator reports ready, and is
// then held on a valid/ack result port.
// Optional build macro: ARRAY_FEED_STATS_EN adds the bubble_cnt output, which
// counts zero-fill ACCU cycles.
module array_feed_pl #(
  parameter int CACHE_WIDTH = 512,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_AW     = 3,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   num_lines,
  input  logic                   rx_valid,
  input  logic [CACHE_WIDTH-1:0] rx_data,
  output logic                   rx_ready,
  output logic                   acc_inc,
  output logic [CACHE_WIDTH-1:0] acc_array,
  input  logic [CACHE_WIDTH-1:0] acc_res,
  input  logic                   acc_ready,
  output logic                   res_valid,
  output logic [CACHE_WIDTH-1:0] res_data,
  input  logic                   res_ack,
  output logic                   busy
`ifdef ARRAY_FEED_STATS_EN
  ,
  output logic [31:0]            bubble_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LANES = CACHE_WIDTH / DATA_WIDTH;
  // A zero-fill line is simply every lane at zero.
  localparam logic [CACHE_WIDTH-1:0] ZERO_LINE = {LANES{{DATA_WIDTH{1'b0}}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCU  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [CACHE_WIDTH-1:0] res_data_q, res_data_d;
  logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic                   full_q, full_d;
  logic [CACHE_WIDTH-1:0] mem_q [DEPTH];

  logic                   empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic [FIFO_AW-1:0]     wr_inc_s;
  logic                   acc_inc_s;
  logic [CACHE_WIDTH-1:0] acc_array_s;

  assign empty_s  = (wr_ptr_q == rd_ptr_q) && !full_q;
  assign push_s   = rx_valid && !full_q;
  assign pop_s    = (state_q == S_ACCU) && !empty_s;
  assign wr_inc_s = wr_ptr_q + FIFO_AW'(1);

  // FIFO pointer and full-flag next state; a push while full is blocked by rx_ready.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    if (push_s) begin
      wr_ptr_d = wr_inc_s;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      full_d = (wr_inc_s == rd_ptr_q);
    end else if (pop_s && !push_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // FIFO storage; contents are discarded on reset through the pointers only.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Sequencer next state, line countdown, result capture and accumulator drive.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    res_data_d  = res_data_q;
    acc_inc_s   = 1'b0;
    acc_array_s = ZERO_LINE;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_lines == '0) begin
            res_data_d = ZERO_LINE;
            state_d    = S_HOLD;
          end else begin
            rem_d   = num_lines;
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_ACCU;
      end
      S_ACCU: begin
        // inc stays high even when starved: adding a zero line keeps the run contiguous.
        acc_inc_s = 1'b1;
        if (!empty_s) begin
          acc_array_s = mem_q[rd_ptr_q];
          rem_d       = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ACCU;
          end
        end else begin
          acc_array_s = ZERO_LINE;
        end
      end
      S_DRAIN: begin
        if (acc_ready) begin
          res_data_d = acc_res;
          state_d    = S_HOLD;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (res_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      res_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      res_data_q <= res_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
    end
  end

  assign rx_ready  = !full_q;
  assign acc_inc   = acc_inc_s;
  assign acc_array = acc_array_s;
  assign res_valid = (state_q == S_HOLD);
  assign res_data  = res_data_q;
  assign busy      = (state_q != S_IDLE);

`ifdef ARRAY_FEED_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Bubble count: cleared by an accepted start, saturating count of starved ACCU cycles.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((state_q == S_IDLE) && start) begin
      bubble_cnt_d = 32'd0;
    end else if ((state_q == S_ACCU) && empty_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Bubble count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_array_feed_pl.sv
// Testbench for array_feed_pl: a behavioural accumulator stands in for the real
// one; a scoreboard queue holds expected results and a monitor acknowledges and
// checks every result the DUT presents.
module tb_array_feed_pl;
  localparam int CW = 512;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] num_lines = '0;
  logic          rx_valid = 1'b0;
  logic [CW-1:0] rx_data = '0;
  logic          rx_ready;
  logic          acc_inc;
  logic [CW-1:0] acc_array;
  logic [CW-1:0] acc_res;
  logic          acc_ready;
  logic          res_valid;
  logic [CW-1:0] res_data;
  logic          res_ack = 1'b0;
  logic          busy;
`ifdef ARRAY_FEED_STATS_EN
  logic [31:0]   bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int job_c0 = 0;
  bit sent_done = 1'b0;

  typedef struct {
    logic [CW-1:0] d;
    int            c;
  } exp_t;
  exp_t exp_q[$];

  array_feed_pl dut (
    .clk(clk), .rst(rst), .start(start), .num_lines(num_lines),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .acc_inc(acc_inc), .acc_array(acc_array), .acc_res(acc_res),
    .acc_ready(acc_ready), .res_valid(res_valid), .res_data(res_data),
    .res_ack(res_ack), .busy(busy)
`ifdef ARRAY_FEED_STATS_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in accumulator: loads array when inc is low, adds lane-wise when high;
  // ready follows inc by one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_res   <= '0;
      acc_ready <= 1'b0;
    end else begin
      for (int l = 0; l < CW / 32; l++) begin
        if (acc_inc) acc_res[l*32 +: 32] <= acc_res[l*32 +: 32] + acc_array[l*32 +: 32];
        else         acc_res[l*32 +: 32] <= acc_array[l*32 +: 32];
      end
      acc_ready <= acc_inc;
    end
  end

  function automatic logic [CW-1:0] fill(input logic [31:0] v);
    return {(CW/32){v}};
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Offer one line, holding rx_valid until accepted; call at a negedge.
  task automatic send(input logic [CW-1:0] d);
    int t;
    rx_valid = 1'b1;
    rx_data  = d;
    t = 0;
    while (!rx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("send_timeout", 1'b0, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Pulse start and queue the expected result; returns one cycle after start.
  task automatic start_job(input int n, input logic [CW-1:0] e, input int lat);
    exp_t x;
    job_c0    = cyc;
    x.d       = e;
    x.c       = (lat < 0) ? -1 : job_c0 + lat;
    exp_q.push_back(x);
    start     = 1'b1;
    num_lines = LW'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(nm, busy, 1'b0);
  endtask

  // Monitor: acknowledge each presented result and compare against the scoreboard.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (res_valid && !res_ack && !rst) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1'b1, 1'b0);
        end else begin
          x = exp_q.pop_front();
          chk("res_data", res_data, x.d);
          if (x.c >= 0) chk("res_valid_cycle", CW'(cyc), CW'(x.c));
        end
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
      end
    end
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_acc_inc", acc_inc, 1'b0);
    chk("rst_acc_array", acc_array, '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, '0);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: prefilled 4 lines of 1,2,3,4 -> 10 per lane, result at cycle 7.
    for (int i = 1; i <= 4; i++) send(fill(32'(i)));
    start_job(4, fill(32'd10), 7);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("t1_inc_k%0d", k), acc_inc, (k >= 2 && k <= 5));
      if (k == 2) chk("t1_array_head", acc_array, fill(32'd1));
      @(negedge clk);
    end
    wait_idle("t1_idle");

    // 2: empty FIFO, lines at cycles 4, 9, 10 -> bubbles, lane0 15, result at 13.
    start_job(3, {{(CW-32){1'b0}}, 32'd15}, 13);
    while (cyc < job_c0 + 3) @(negedge clk);
    chk("t2_bubble_inc", acc_inc, 1'b1);
    chk("t2_bubble_zero", acc_array, '0);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = {{(CW-32){1'b0}}, 32'd5};
    @(negedge clk);
    rx_valid = 1'b0;
    while (cyc < job_c0 + 9) @(negedge clk);
    rx_valid = 1'b1;
    @(negedge clk);
    chk("t2_inc_held", acc_inc, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle("t2_idle");
`ifdef ARRAY_FEED_STATS_EN
    chk("t2_bubble_cnt", CW'(bubble_cnt), CW'(32'd7));
`endif

    // 3: zero-length job -> result next cycle, zero, no inc.
    start_job(0, '0, 1);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("t3_no_inc_k%0d", k), acc_inc, 1'b0);
      @(negedge clk);
    end
    wait_idle("t3_idle");

    // 4: 9 lines into depth 8, job of 2 frees room, 7 remain for the next job.
    fork
      begin
        for (int i = 0; i < 9; i++) send(fill(32'(i + 1)));
        sent_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    chk("t4_full_rx_ready", rx_ready, 1'b0);
    start_job(2, fill(32'd3), 5);
    wait_idle("t4_idle");
    for (int t = 0; t < 50 && !sent_done; t++) @(negedge clk);
    chk("t4_ninth_accepted", sent_done, 1'b1);
    chk("t4_rx_ready_back", rx_ready, 1'b1);
    start_job(7, fill(32'd42), 10);
    wait_idle("t4b_idle");

    // 5: lane wrap 0xFFFFFFFF + 2 = 1.
    send(fill(32'hFFFF_FFFF));
    send(fill(32'h0000_0002));
    start_job(2, fill(32'h0000_0001), 5);
    wait_idle("t5_idle");

    // 6: reset in ACCU after 2 of 5 lines; FIFO contents discarded.
    for (int i = 0; i < 5; i++) send(fill(32'd100));
    job_c0 = cyc;
    start = 1'b1; num_lines = LW'(5);
    @(negedge clk);
    start = 1'b0;
    while (cyc < job_c0 + 4) @(negedge clk);
    chk("t6_in_accu", acc_inc, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_inc", acc_inc, 1'b0);
    chk("t6_rst_array", acc_array, '0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_res_valid", res_valid, 1'b0);
    chk("t6_rst_res_data", res_data, '0);
    chk("t6_rst_rx_ready", rx_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(fill(32'd7));
    start_job(1, fill(32'd7), 4);
    wait_idle("t6_idle");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", CW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
